// File: rtl/square_attack_scanner.sv
// Leaper attack scanner: tests one candidate attacker square per clock
// (pawns, knights, king) against a board captured when the request is accepted.

package square_attack_pkg;
  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    PAWN   = 3'd1,
    KNIGHT = 3'd2,
    BISHOP = 3'd3,
    ROOK   = 3'd4,
    QUEEN  = 3'd5,
    KING   = 3'd6
  } piece_t;

  typedef enum logic {
    WHITE = 1'b0,
    BLACK = 1'b1
  } color_t;

  typedef struct packed {
    color_t color;
    piece_t piece;
  } fullpiece_t;
endpackage

module square_attack_scanner
  import square_attack_pkg::*;
#(
  parameter int unsigned ENABLE_PAWN   = 1,
  parameter int unsigned ENABLE_KNIGHT = 1,
  parameter int unsigned ENABLE_KING   = 1,
  parameter int unsigned EARLY_EXIT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  fullpiece_t [63:0] board,
  input  logic [5:0]        square,
  input  color_t            defender,
  output logic              busy,
  output logic              done,
  output logic              attacked,
  output logic [5:0]        attacker_square,
  output piece_t            attacker_piece,
  output logic [4:0]        hit_count
);

  // Candidate counts per class; disabled classes contribute nothing.
  localparam logic [4:0] N_PAWN_C   = 5'(2 * ENABLE_PAWN);
  localparam logic [4:0] N_KNIGHT_C = 5'(8 * ENABLE_KNIGHT);
  localparam logic [4:0] N_KING_C   = 5'(8 * ENABLE_KING);
  localparam logic [4:0] N_TOTAL_C  = N_PAWN_C + N_KNIGHT_C + N_KING_C;

  if (ENABLE_PAWN == 0 && ENABLE_KNIGHT == 0 && ENABLE_KING == 0) begin : g_cfg_check
    $error("square_attack_scanner: at least one candidate class must be enabled");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  fullpiece_t [63:0] board_r;
  logic [5:0]        square_r;
  color_t            defender_r;
  logic [4:0]        idx_r;

  // Second pipeline stage: the candidate produced from idx_r one cycle earlier.
  logic              cand_v_r;
  logic              cand_ok_r;
  logic              cand_last_r;
  logic [5:0]        cand_sq_r;
  piece_t            cand_type_r;

  logic              busy_r;
  logic              done_r;
  logic              attacked_r;
  logic [5:0]        attacker_square_r;
  piece_t            attacker_piece_r;
  logic [4:0]        hit_count_r;

  // First-stage decode of candidate idx_r.
  piece_t            cand_type_s;
  logic signed [3:0] dr_s;
  logic signed [3:0] dc_s;
  logic [4:0]        kn_sub_s;
  logic [4:0]        kg_sub_s;
  logic signed [3:0] row_s;
  logic signed [3:0] col_s;
  logic              cand_ok_s;
  logic [5:0]        cand_sq_s;
  logic              hit_s;

  // Map the scan index onto a piece class and a (dr,dc) offset in scan order.
  always_comb begin
    cand_type_s = EMPTY;
    dr_s        = 4'sd0;
    dc_s        = 4'sd0;
    kn_sub_s    = idx_r - N_PAWN_C;
    kg_sub_s    = idx_r - N_PAWN_C - N_KNIGHT_C;
    if (idx_r < N_PAWN_C) begin
      // White pawns advance toward higher rows, so they attack from below.
      cand_type_s = PAWN;
      dr_s        = (defender_r == WHITE) ? 4'sd1 : -4'sd1;
      dc_s        = idx_r[0] ? 4'sd1 : -4'sd1;
    end else if (idx_r < (N_PAWN_C + N_KNIGHT_C)) begin
      cand_type_s = KNIGHT;
      case (kn_sub_s[2:0])
        3'd0:    begin dr_s =  4'sd2; dc_s =  4'sd1; end
        3'd1:    begin dr_s =  4'sd2; dc_s = -4'sd1; end
        3'd2:    begin dr_s = -4'sd2; dc_s =  4'sd1; end
        3'd3:    begin dr_s = -4'sd2; dc_s = -4'sd1; end
        3'd4:    begin dr_s =  4'sd1; dc_s =  4'sd2; end
        3'd5:    begin dr_s =  4'sd1; dc_s = -4'sd2; end
        3'd6:    begin dr_s = -4'sd1; dc_s =  4'sd2; end
        3'd7:    begin dr_s = -4'sd1; dc_s = -4'sd2; end
        default: begin dr_s =  4'sd0; dc_s =  4'sd0; end
      endcase
    end else if (idx_r < N_TOTAL_C) begin
      cand_type_s = KING;
      case (kg_sub_s[2:0])
        3'd0:    begin dr_s = -4'sd1; dc_s = -4'sd1; end
        3'd1:    begin dr_s = -4'sd1; dc_s =  4'sd0; end
        3'd2:    begin dr_s = -4'sd1; dc_s =  4'sd1; end
        3'd3:    begin dr_s =  4'sd0; dc_s = -4'sd1; end
        3'd4:    begin dr_s =  4'sd0; dc_s =  4'sd1; end
        3'd5:    begin dr_s =  4'sd1; dc_s = -4'sd1; end
        3'd6:    begin dr_s =  4'sd1; dc_s =  4'sd0; end
        3'd7:    begin dr_s =  4'sd1; dc_s =  4'sd1; end
        default: begin dr_s =  4'sd0; dc_s =  4'sd0; end
      endcase
    end else begin
      cand_type_s = EMPTY;
    end
  end

  // Target coordinates in 4-bit signed form; bit 3 set means off the board.
  always_comb begin
    row_s     = $signed({1'b0, square_r[5:3]}) + dr_s;
    col_s     = $signed({1'b0, square_r[2:0]}) + dc_s;
    cand_ok_s = ~row_s[3] & ~col_s[3] & (idx_r < N_TOTAL_C);
    cand_sq_s = {row_s[2:0], col_s[2:0]};
  end

  // Second stage: an enemy piece of the candidate's class sits on the square.
  always_comb begin
    hit_s = 1'b0;
    if (cand_v_r && cand_ok_r && (cand_type_r != EMPTY)) begin
      hit_s = (board_r[cand_sq_r].piece == cand_type_r) &&
              (board_r[cand_sq_r].color != defender_r);
    end else begin
      hit_s = 1'b0;
    end
  end

  // Control FSM with candidate pipeline and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r           <= ST_IDLE;
      board_r           <= '0;
      square_r          <= 6'd0;
      defender_r        <= WHITE;
      idx_r             <= 5'd0;
      cand_v_r          <= 1'b0;
      cand_ok_r         <= 1'b0;
      cand_last_r       <= 1'b0;
      cand_sq_r         <= 6'd0;
      cand_type_r       <= EMPTY;
      busy_r            <= 1'b0;
      done_r            <= 1'b0;
      attacked_r        <= 1'b0;
      attacker_square_r <= 6'd0;
      attacker_piece_r  <= EMPTY;
      hit_count_r       <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            board_r           <= board;
            square_r          <= square;
            defender_r        <= defender;
            idx_r             <= 5'd0;
            cand_v_r          <= 1'b0;
            attacked_r        <= 1'b0;
            attacker_square_r <= 6'd0;
            attacker_piece_r  <= EMPTY;
            hit_count_r       <= 5'd0;
            busy_r            <= 1'b1;
            state_r           <= ST_SCAN;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (abort) begin
            cand_v_r <= 1'b0;
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end else begin
            // Stage one: issue the next candidate while any remain.
            if (idx_r < N_TOTAL_C) begin
              cand_v_r    <= 1'b1;
              cand_ok_r   <= cand_ok_s;
              cand_sq_r   <= cand_sq_s;
              cand_type_r <= cand_type_s;
              cand_last_r <= (idx_r == (N_TOTAL_C - 5'd1));
              idx_r       <= idx_r + 5'd1;
            end else begin
              cand_v_r <= 1'b0;
            end
            // Stage two: record hits and decide whether the scan is over.
            if (cand_v_r) begin
              if (hit_s) begin
                if (!attacked_r) begin
                  attacked_r        <= 1'b1;
                  attacker_square_r <= cand_sq_r;
                  attacker_piece_r  <= cand_type_r;
                end
                hit_count_r <= hit_count_r + 5'd1;
              end
              if (cand_last_r || (hit_s && (EARLY_EXIT != 0))) begin
                done_r  <= 1'b1;
                state_r <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          // busy stays high through this cycle so a coincident start is dropped.
          done_r   <= 1'b0;
          busy_r   <= 1'b0;
          cand_v_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          done_r   <= 1'b0;
          busy_r   <= 1'b0;
          cand_v_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign attacked        = attacked_r;
  assign attacker_square = attacker_square_r;
  assign attacker_piece  = attacker_piece_r;
  assign hit_count       = hit_count_r;

endmodule

// File: tb/tb_square_attack_scanner.sv
// Scoreboard bench for square_attack_scanner: one early-exit instance and one
// full-count instance share board/square/defender and reset.

module tb_square_attack_scanner;
  import square_attack_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_a, start_b, abort_a, abort_b;
  fullpiece_t [63:0] board;
  logic [5:0]        square;
  color_t            defender;

  logic       busy_a, done_a, att_a, busy_b, done_b, att_b;
  logic [5:0] asq_a, asq_b;
  piece_t     apc_a, apc_b;
  logic [4:0] cnt_a, cnt_b;

  square_attack_scanner #(.ENABLE_PAWN(1), .ENABLE_KNIGHT(1), .ENABLE_KING(1), .EARLY_EXIT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .board(board), .square(square),
    .defender(defender), .busy(busy_a), .done(done_a), .attacked(att_a),
    .attacker_square(asq_a), .attacker_piece(apc_a), .hit_count(cnt_a));

  square_attack_scanner #(.ENABLE_PAWN(1), .ENABLE_KNIGHT(1), .ENABLE_KING(1), .EARLY_EXIT(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .board(board), .square(square),
    .defender(defender), .busy(busy_b), .done(done_b), .attacked(att_b),
    .attacker_square(asq_b), .attacker_piece(apc_b), .hit_count(cnt_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       att;
    logic [5:0] sq;
    piece_t     pc;
    logic [4:0] cnt;
    int         dcyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string who, input exp_t e, input logic att, input logic [5:0] sq,
                         input piece_t pc, input logic [4:0] cnt);
    chk({who, " done cycle"}, cyc, e.dcyc);
    chk({who, " attacked"}, int'(att), int'(e.att));
    chk({who, " attacker_square"}, int'(sq), int'(e.sq));
    chk({who, " attacker_piece"}, int'(pc), int'(e.pc));
    chk({who, " hit_count"}, int'(cnt), int'(e.cnt));
  endtask

  // Monitor for the early-exit instance.
  always @(negedge clk) begin
    if (!rst && done_a) begin
      if (q_a.size() == 0) begin
        chk("dut_a unexpected done", 1, 0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        compare("dut_a", e, att_a, asq_a, apc_a, cnt_a);
      end
    end
  end

  // Monitor for the full-count instance.
  always @(negedge clk) begin
    if (!rst && done_b) begin
      if (q_b.size() == 0) begin
        chk("dut_b unexpected done", 1, 0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        compare("dut_b", e, att_b, asq_b, apc_b, cnt_b);
      end
    end
  end

  // Called at a falling edge; the next rising edge accepts. Returns mid cycle 0.
  task automatic issue(input bit sel_b, input bit push, input logic att, input logic [5:0] sq,
                       input piece_t pc, input logic [4:0] cnt, input int lat);
    exp_t e;
    e.att  = att;
    e.sq   = sq;
    e.pc   = pc;
    e.cnt  = cnt;
    e.dcyc = cyc + 1 + lat;
    if (push) begin
      if (sel_b) q_b.push_back(e);
      else       q_a.push_back(e);
    end
    if (sel_b) start_b = 1'b1;
    else       start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (q_a.size() + q_b.size()) != 0; i++) @(negedge clk);
    chk("scoreboard drained", q_a.size() + q_b.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  function automatic fullpiece_t fp(input color_t c, input piece_t p);
    fullpiece_t f;
    f.color = c;
    f.piece = p;
    return f;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
    board = '0; square = 6'd0; defender = WHITE;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset busy", int'(busy_a), 0);
    chk("reset done", int'(done_a), 0);
    chk("reset attacked", int'(att_a), 0);
    chk("reset attacker_square", int'(asq_a), 0);
    chk("reset attacker_piece", int'(apc_a), int'(EMPTY));
    chk("reset hit_count", int'(cnt_b), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Pawn hit from the first candidate.
    square = 6'd28; defender = WHITE; board[35] = fp(BLACK, PAWN);
    issue(1'b0, 1'b1, 1'b1, 6'd35, PAWN, 5'd1, 2);  drain();
    issue(1'b1, 1'b1, 1'b1, 6'd35, PAWN, 5'd1, 19); drain();
    // Own-colour pawn and a wrong piece type never hit.
    board[35] = fp(WHITE, PAWN);
    issue(1'b0, 1'b1, 1'b0, 6'd0, EMPTY, 5'd0, 19); drain();
    board[35] = fp(BLACK, BISHOP);
    issue(1'b0, 1'b1, 1'b0, 6'd0, EMPTY, 5'd0, 19); drain();

    // Corner square: no wrap onto the far edge, then a knight hit.
    board = '0; square = 6'd0; board[15] = fp(BLACK, PAWN);
    issue(1'b0, 1'b1, 1'b0, 6'd0, EMPTY, 5'd0, 19); drain();
    board[10] = fp(BLACK, KNIGHT);
    issue(1'b0, 1'b1, 1'b1, 6'd10, KNIGHT, 5'd1, 8); drain();
    board = '0; square = 6'd7; board[17] = fp(BLACK, KNIGHT);
    issue(1'b0, 1'b1, 1'b0, 6'd0, EMPTY, 5'd0, 19); drain();

    // King at (-1,0) is candidate 11.
    board = '0; square = 6'd28; board[20] = fp(BLACK, KING);
    issue(1'b0, 1'b1, 1'b1, 6'd20, KING, 5'd1, 13); drain();

    // Black defender, full count.
    board = '0; square = 6'd36; defender = BLACK;
    board[27] = fp(WHITE, PAWN); board[53] = fp(WHITE, KNIGHT);
    issue(1'b1, 1'b1, 1'b1, 6'd27, PAWN, 5'd2, 19); drain();
    issue(1'b0, 1'b1, 1'b1, 6'd27, PAWN, 5'd1, 2);  drain();

    // Four attackers from three classes.
    board = '0; square = 6'd28; defender = WHITE;
    board[35] = fp(BLACK, PAWN); board[37] = fp(BLACK, PAWN);
    board[45] = fp(BLACK, KNIGHT); board[19] = fp(BLACK, KING);
    issue(1'b1, 1'b1, 1'b1, 6'd35, PAWN, 5'd4, 19); drain();

    // Empty board: busy through cycle 19 only.
    board = '0;
    issue(1'b0, 1'b1, 1'b0, 6'd0, EMPTY, 5'd0, 19);
    for (int i = 0; i <= 20; i++) begin
      chk($sformatf("busy in cycle %0d", i), int'(busy_a), (i <= 19) ? 1 : 0);
      @(negedge clk);
    end
    drain();
    issue(1'b1, 1'b1, 1'b0, 6'd0, EMPTY, 5'd0, 19); drain();

    // Handshake: board edit and extra starts while busy are ignored.
    board = '0;
    issue(1'b0, 1'b1, 1'b0, 6'd0, EMPTY, 5'd0, 19);
    repeat (3) @(negedge clk);
    board[35] = fp(BLACK, PAWN);
    repeat (2) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (13) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    issue(1'b0, 1'b1, 1'b1, 6'd35, PAWN, 5'd1, 2); drain();

    // Abort mid-scan: no done pulse, then a normal scan.
    board = '0;
    issue(1'b0, 1'b0, 1'b0, 6'd0, EMPTY, 5'd0, 19);
    repeat (4) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("busy after abort", int'(busy_a), 0);
    repeat (25) @(negedge clk);
    board[35] = fp(BLACK, PAWN);
    issue(1'b0, 1'b1, 1'b1, 6'd35, PAWN, 5'd1, 2); drain();

    // Reset mid-scan clears outputs without waiting for a clock edge.
    board = '0; square = 6'd36; defender = BLACK; board[27] = fp(WHITE, PAWN);
    issue(1'b1, 1'b0, 1'b0, 6'd0, EMPTY, 5'd0, 19);
    repeat (6) @(negedge clk);
    chk("partial hit before reset", int'(att_b), 1);
    rst = 1'b1;
    #1;
    chk("async reset busy", int'(busy_b), 0);
    chk("async reset attacked", int'(att_b), 0);
    chk("async reset attacker_square", int'(asq_b), 0);
    chk("async reset hit_count", int'(cnt_b), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b1, 1'b1, 1'b1, 6'd27, PAWN, 5'd1, 19); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
